// File: rtl/generic_if_responder.sv
// Responder end of the generic request/response interface: FIFO-buffered requests,
// fixed-latency data+1 responses with a wrapping tag. Optional parity: GENERIC_IF_RSP_PARITY_EN.
module generic_if_responder #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [WIDTH-1:0]         i_req_data,
`ifdef GENERIC_IF_RSP_PARITY_EN
  input  logic                     i_req_parity,
  output logic                     o_rsp_parity,
`endif
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic [TAG_W-1:0]         o_rsp_tag,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PW-1:0]     level;
  logic              full, push, pop;
  logic [WIDTH-1:0]  head, head_inc;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push     = i_req_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_inc = head + WIDTH'(1);

`ifdef GENERIC_IF_RSP_PARITY_EN
  logic mem_par_q [DEPTH];
  logic rsp_parity_q, rsp_parity_d;
  logic head_par;
  assign head_par = mem_par_q[rd_ptr_q[AW-1:0]];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    pop         = 1'b0;
`ifdef GENERIC_IF_RSP_PARITY_EN
    rsp_parity_d = rsp_parity_q;
`endif
    case (state_q)
      S_IDLE: pop = (level != '0);
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_tag_d = rsp_tag_q + TAG_W'(1);
          if (level != '0) begin
            pop = 1'b1;
          end else begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pop from IDLE or from an accepted RESP loads the hold register directly,
    // so back-to-back responses carry no IDLE bubble.
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      rsp_data_d = head_inc;
`ifdef GENERIC_IF_RSP_PARITY_EN
      rsp_parity_d = (^head_inc) ^ (head_par ^ (^head));
`endif
      if (LATENCY == 0) begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
      end else begin
        state_d     = S_WAIT;
        cnt_d       = CNT_INIT;
        rsp_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
`ifdef GENERIC_IF_RSP_PARITY_EN
      rsp_parity_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
`ifdef GENERIC_IF_RSP_PARITY_EN
      rsp_parity_q <= rsp_parity_d;
`endif
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_req_data;
`ifdef GENERIC_IF_RSP_PARITY_EN
      mem_par_q[wr_ptr_q[AW-1:0]] <= i_req_parity;
`endif
    end
  end

  assign o_req_ready = !full;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_level     = level;
`ifdef GENERIC_IF_RSP_PARITY_EN
  assign o_rsp_parity = rsp_parity_q;
`endif

endmodule

// File: tb/tb_generic_if_responder.sv
// Directed bench for generic_if_responder: instance a at LATENCY=2, instance b at LATENCY=0.
module tb_generic_if_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [7:0] a_req_data, a_rsp_data;
  logic [3:0] a_rsp_tag;
  logic [2:0] a_level;
  logic       b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [7:0] b_req_data, b_rsp_data;
  logic [3:0] b_rsp_tag;
  logic [2:0] b_level;
`ifdef GENERIC_IF_RSP_PARITY_EN
  logic a_req_parity, a_rsp_parity, b_rsp_parity;
  logic b_req_parity;
  assign b_req_parity = ^b_req_data;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  generic_if_responder #(.WIDTH(8), .DEPTH(4), .LATENCY(2), .TAG_W(4)) dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_data(a_req_data),
`ifdef GENERIC_IF_RSP_PARITY_EN
    .i_req_parity(a_req_parity), .o_rsp_parity(a_rsp_parity),
`endif
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready), .o_rsp_data(a_rsp_data),
    .o_rsp_tag(a_rsp_tag), .o_level(a_level)
  );

  generic_if_responder #(.WIDTH(8), .DEPTH(4), .LATENCY(0), .TAG_W(4)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_data(b_req_data),
`ifdef GENERIC_IF_RSP_PARITY_EN
    .i_req_parity(b_req_parity), .o_rsp_parity(b_rsp_parity),
`endif
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready), .o_rsp_data(b_rsp_data),
    .o_rsp_tag(b_rsp_tag), .o_level(b_level)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_req_valid = 1'b0; a_req_data = '0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_data = '0; b_rsp_ready = 1'b1;
`ifdef GENERIC_IF_RSP_PARITY_EN
    a_req_parity = 1'b0;
`endif
    step; step;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", a_rsp_valid); else passed++;
    total++; if (a_req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", a_req_ready); else passed++;
    total++; if (a_rsp_data !== 8'h00) $display("FAIL reset_data got %h want 00", a_rsp_data); else passed++;
    total++; if (a_rsp_tag !== 4'd0) $display("FAIL reset_tag got %0d want 0", a_rsp_tag); else passed++;
    total++; if (a_level !== 3'd0) $display("FAIL reset_level got %0d want 0", a_level); else passed++;
    rst = 1'b0;
    step;
  endtask

  // Push 0x41; valid must first appear after the 4th edge counted from the push edge.
  task automatic test_single;
    a_req_valid = 1'b1; a_req_data = 8'h41;
    step;
    a_req_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      total++; if (a_rsp_valid !== 1'b0) $display("FAIL single_early_valid cycle %0d got %b want 0", k, a_rsp_valid); else passed++;
      step;
    end
    total++; if (a_rsp_valid !== 1'b1) $display("FAIL single_valid got %b want 1", a_rsp_valid); else passed++;
    total++; if (a_rsp_data !== 8'h42) $display("FAIL single_data got %h want 42", a_rsp_data); else passed++;
    total++; if (a_rsp_tag !== 4'd0) $display("FAIL single_tag got %0d want 0", a_rsp_tag); else passed++;
    a_rsp_ready = 1'b1;
    step;
    a_rsp_ready = 1'b0;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL single_drop got %b want 0", a_rsp_valid); else passed++;
    total++; if (a_rsp_tag !== 4'd1) $display("FAIL single_tag_inc got %0d want 1", a_rsp_tag); else passed++;
  endtask

  task automatic test_wrap;
    int n;
    a_req_valid = 1'b1; a_req_data = 8'hFF;
    step;
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin step; n++; end
    total++; if (a_rsp_valid !== 1'b1) $display("FAIL wrap_timeout got %b want 1", a_rsp_valid); else passed++;
    total++; if (a_rsp_data !== 8'h00) $display("FAIL wrap_data got %h want 00", a_rsp_data); else passed++;
    total++; if (a_rsp_tag !== 4'd1) $display("FAIL wrap_tag got %0d want 1", a_rsp_tag); else passed++;
    a_rsp_ready = 1'b1;
    step;
    a_rsp_ready = 1'b0;
  endtask

  task automatic test_full;
    int n;
    logic [7:0] exp_d;
    logic [3:0] exp_t;
    for (int k = 0; k < 8; k++) begin
      a_req_valid = 1'b1; a_req_data = 8'h10 + 8'(k);
      step;
      if (k >= 4) begin
        total++; if (a_req_ready !== 1'b0) $display("FAIL full_ready k=%0d got %b want 0", k, a_req_ready); else passed++;
        total++; if (a_level !== 3'd4) $display("FAIL full_level k=%0d got %0d want 4", k, a_level); else passed++;
      end
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      exp_d = 8'h11 + 8'(j);
      exp_t = 4'd2 + 4'(j);
      n = 0;
      while (!a_rsp_valid && n < 20) begin step; n++; end
      total++; if (a_rsp_valid !== 1'b1) $display("FAIL drain_timeout j=%0d got %b want 1", j, a_rsp_valid); else passed++;
      total++; if (a_rsp_data !== exp_d) $display("FAIL drain_data j=%0d got %h want %h", j, a_rsp_data, exp_d); else passed++;
      total++; if (a_rsp_tag !== exp_t) $display("FAIL drain_tag j=%0d got %0d want %0d", j, a_rsp_tag, exp_t); else passed++;
      step;
    end
    a_rsp_ready = 1'b0;
    total++; if (a_level !== 3'd0) $display("FAIL drain_level got %0d want 0", a_level); else passed++;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL drain_idle got %b want 0", a_rsp_valid); else passed++;
  endtask

  task automatic test_backpressure;
    int n;
    a_req_valid = 1'b1; a_req_data = 8'h30;
    step;
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin step; n++; end
    for (int k = 0; k < 3; k++) begin
      step;
      total++; if (a_rsp_valid !== 1'b1) $display("FAIL bp_valid k=%0d got %b want 1", k, a_rsp_valid); else passed++;
      total++; if (a_rsp_data !== 8'h31) $display("FAIL bp_data k=%0d got %h want 31", k, a_rsp_data); else passed++;
      total++; if (a_rsp_tag !== 4'd7) $display("FAIL bp_tag k=%0d got %0d want 7", k, a_rsp_tag); else passed++;
    end
    a_rsp_ready = 1'b1;
    step;
    a_rsp_ready = 1'b0;
    step;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL bp_release got %b want 0", a_rsp_valid); else passed++;
    total++; if (a_rsp_tag !== 4'd8) $display("FAIL bp_one_xfer got %0d want 8", a_rsp_tag); else passed++;
  endtask

  // Brings a response up, queues 4 more, accepts one so 3 sit queued while in WAIT, then resets.
  task automatic test_reset_mid;
    int n;
    a_req_valid = 1'b1; a_req_data = 8'h60;
    step;
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin step; n++; end
    for (int k = 1; k <= 4; k++) begin
      a_req_valid = 1'b1; a_req_data = 8'h60 + 8'(k);
      step;
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    step;
    a_rsp_ready = 1'b0;
    total++; if (a_level !== 3'd3) $display("FAIL mid_level_pre got %0d want 3", a_level); else passed++;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_wait_pre got %b want 0", a_rsp_valid); else passed++;
    rst = 1'b1;
    #2;
    step;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", a_rsp_valid); else passed++;
    total++; if (a_level !== 3'd0) $display("FAIL mid_rst_level got %0d want 0", a_level); else passed++;
    total++; if (a_req_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", a_req_ready); else passed++;
    total++; if (a_rsp_tag !== 4'd0) $display("FAIL mid_rst_tag got %0d want 0", a_rsp_tag); else passed++;
    rst = 1'b0;
    step; step; step;
    total++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_post_valid got %b want 0", a_rsp_valid); else passed++;
  endtask

  // LATENCY=0, ready high: responses from start+1 on consecutive cycles with tags from tag0.
  task automatic run_stream(input int start, input int cnt, input logic [3:0] tag0, input string nm);
    logic [7:0] exp_d;
    logic [3:0] exp_t;
    b_rsp_ready = 1'b1;
    for (int k = 0; k <= cnt + 1; k++) begin
      b_req_valid = (k < cnt);
      b_req_data  = 8'(start + k);
      step;
      if (k >= 1 && k <= cnt) begin
        exp_d = 8'(start + k);
        exp_t = tag0 + 4'(k - 1);
        total++; if (b_rsp_valid !== 1'b1) $display("FAIL %s_valid k=%0d got %b want 1", nm, k, b_rsp_valid); else passed++;
        total++; if (b_rsp_data !== exp_d) $display("FAIL %s_data k=%0d got %h want %h", nm, k, b_rsp_data, exp_d); else passed++;
        total++; if (b_rsp_tag !== exp_t) $display("FAIL %s_tag k=%0d got %0d want %0d", nm, k, b_rsp_tag, exp_t); else passed++;
      end
    end
    exp_t = tag0 + 4'(cnt);
    total++; if (b_rsp_valid !== 1'b0) $display("FAIL %s_end_valid got %b want 0", nm, b_rsp_valid); else passed++;
    total++; if (b_rsp_tag !== exp_t) $display("FAIL %s_end_tag got %0d want %0d", nm, b_rsp_tag, exp_t); else passed++;
  endtask

  task automatic test_back_to_back;
    run_stream(0, 8, 4'd0, "b2b");
  endtask

  task automatic test_tag_wrap;
    run_stream(8, 9, 4'd8, "tagwrap");
  endtask

`ifdef GENERIC_IF_RSP_PARITY_EN
  task automatic test_parity;
    int n;
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1; a_req_data = 8'h03; a_req_parity = ~(^8'h03);
    step;
    a_req_data = 8'h06; a_req_parity = ^8'h06;
    step;
    a_req_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin step; n++; end
    total++; if (a_rsp_data !== 8'h04) $display("FAIL par_bad_data got %h want 04", a_rsp_data); else passed++;
    total++; if (a_rsp_parity !== 1'b0) $display("FAIL par_bad got %b want 0", a_rsp_parity); else passed++;
    a_rsp_ready = 1'b1;
    step;
    n = 0;
    while (!a_rsp_valid && n < 20) begin step; n++; end
    a_rsp_ready = 1'b0;
    total++; if (a_rsp_data !== 8'h07) $display("FAIL par_good_data got %h want 07", a_rsp_data); else passed++;
    total++; if (a_rsp_parity !== 1'b1) $display("FAIL par_good got %b want 1", a_rsp_parity); else passed++;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_wrap;
    test_full;
    test_backpressure;
    test_back_to_back;
    test_tag_wrap;
    test_reset_mid;
`ifdef GENERIC_IF_RSP_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
